// File: rtl/parking_pkg.sv
// parking_pkg: shared types and widths for the parking gate controller
package parking_pkg;
  localparam int HOUR_W  = 6;
  localparam int COUNT_W = 10;
  typedef enum logic [2:0] {IDLE, PULSE, OPEN, UNDO, CLOSE} state_t;
  typedef enum logic {ENTRY, EXIT} grant_t;
endpackage

// File: rtl/parking_gate_ctrl_sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);
  // count up on inc, clear has priority, stop at the top value
  always_ff @(posedge clk or posedge rst)
    if (rst) o_count <= '0;
    else if (i_clr) o_count <= '0;
    else if (i_inc && o_count != '1) o_count <= o_count + WIDTH'(1);
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: arbitrates entry/exit gate requests, drives occupancy events and barriers
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_HOUR    = 8,
  parameter int OPEN_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOUR_W-1:0] i_current_hour,
  input  logic              i_entry_req,
  input  logic              i_entry_is_uni,
  input  logic              i_exit_req,
  input  logic              i_exit_is_uni,
  input  logic              i_uni_is_vacated_space,
  input  logic              i_is_vacated_space,
  input  logic              i_passed,
  output logic              o_car_entered,
  output logic              o_is_uni_car_entered,
  output logic              o_car_exited,
  output logic              o_is_uni_car_exited,
  output logic              o_entry_gate_open,
  output logic              o_exit_gate_open,
  output logic              o_entry_deny,
  output logic              o_busy,
  output logic [15:0]       o_deny_count,
  output logic [7:0]        o_timeout_count
);
  state_t             r_state, w_next;
  grant_t             r_sel, r_last_grant, w_pick, w_sel_n;
  logic               r_pend_en, r_pend_en_uni, r_pend_ex, r_pend_ex_uni, r_placed_uni;
  logic [COUNT_W-1:0] r_timer;
  logic               w_any, w_admit, w_grant, w_deny, w_timeout, w_undo;
  logic               w_clr_en, w_clr_ex, w_gate_n;
  logic               w_car_entered, w_uni_entered, w_car_exited, w_uni_exited;
  logic               w_entry_gate, w_exit_gate;

  // request selection and admission, evaluated only while idle
  always_comb begin
    w_any     = r_pend_en | r_pend_ex;
    w_pick    = (r_pend_en && r_pend_ex) ? ((r_last_grant == ENTRY) ? EXIT : ENTRY)
              : (r_pend_ex ? EXIT : ENTRY);
    w_admit   = (i_current_hour >= HOUR_W'(OPEN_HOUR)) &&
                (r_pend_en_uni ? (i_uni_is_vacated_space | i_is_vacated_space) : i_is_vacated_space);
    w_grant   = (r_state == IDLE) && w_any && (w_pick == EXIT || w_admit);
    w_deny    = (r_state == IDLE) && w_any && w_pick == ENTRY && !w_admit;
    w_timeout = (r_state == OPEN) && !i_passed && r_timer == COUNT_W'(OPEN_TIMEOUT - 1);
    w_undo    = w_timeout && r_sel == ENTRY;
    w_clr_en  = (w_grant || w_deny) && w_pick == ENTRY;
    w_clr_ex  = w_grant && w_pick == EXIT;
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;

  // next-state logic; passed beats a coincident timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant ? PULSE : IDLE;
      PULSE:   w_next = OPEN;
      OPEN:    w_next = i_passed ? CLOSE : (w_timeout ? (w_undo ? UNDO : CLOSE) : OPEN);
      UNDO:    w_next = CLOSE;
      CLOSE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // output decode, aligned with the state being entered so registered outputs match it
  always_comb begin
    w_sel_n       = (r_state == IDLE) ? w_pick : r_sel;
    w_gate_n      = (w_next == PULSE) || (w_next == OPEN);
    w_entry_gate  = w_gate_n && w_sel_n == ENTRY;
    w_exit_gate   = w_gate_n && w_sel_n == EXIT;
    w_car_entered = w_grant && w_pick == ENTRY;
    w_uni_entered = w_car_entered && r_pend_en_uni;
    w_car_exited  = (w_grant && w_pick == EXIT) || w_undo;
    w_uni_exited  = w_undo ? r_placed_uni : (w_grant && w_pick == EXIT && r_pend_ex_uni);
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_car_entered        <= 1'b0;
      o_is_uni_car_entered <= 1'b0;
      o_car_exited         <= 1'b0;
      o_is_uni_car_exited  <= 1'b0;
      o_entry_gate_open    <= 1'b0;
      o_exit_gate_open     <= 1'b0;
      o_entry_deny         <= 1'b0;
      o_busy               <= 1'b0;
    end else begin
      o_car_entered        <= w_car_entered;
      o_is_uni_car_entered <= w_uni_entered;
      o_car_exited         <= w_car_exited;
      o_is_uni_car_exited  <= w_uni_exited;
      o_entry_gate_open    <= w_entry_gate;
      o_exit_gate_open     <= w_exit_gate;
      o_entry_deny         <= w_deny;
      o_busy               <= w_next != IDLE;
    end

  // pending latches: a new strobe beats a same-cycle clear, a strobe onto a held latch is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend_en     <= 1'b0;
      r_pend_en_uni <= 1'b0;
      r_pend_ex     <= 1'b0;
      r_pend_ex_uni <= 1'b0;
    end else begin
      if (i_entry_req && (!r_pend_en || w_clr_en)) begin
        r_pend_en     <= 1'b1;
        r_pend_en_uni <= i_entry_is_uni;
      end else if (w_clr_en) r_pend_en <= 1'b0;
      if (i_exit_req && (!r_pend_ex || w_clr_ex)) begin
        r_pend_ex     <= 1'b1;
        r_pend_ex_uni <= i_exit_is_uni;
      end else if (w_clr_ex) r_pend_ex <= 1'b0;
    end

  // served gate, placement record for undo, round-robin history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sel        <= ENTRY;
      r_placed_uni <= 1'b0;
      r_last_grant <= ENTRY;
    end else begin
      if (w_grant) begin
        r_sel        <= w_pick;
        r_placed_uni <= (w_pick == ENTRY) && r_pend_en_uni && i_uni_is_vacated_space;
      end
      if (r_state == CLOSE) r_last_grant <= r_sel;
    end

  // barrier open timer
  always_ff @(posedge clk or posedge rst)
    if (rst) r_timer <= '0;
    else if (r_state == PULSE) r_timer <= '0;
    else if (r_state == OPEN) r_timer <= r_timer + COUNT_W'(1);

  sat_counter #(.WIDTH(16)) u_deny_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_deny),
    .i_clr   (1'b0),
    .o_count (o_deny_count)
  );

  sat_counter #(.WIDTH(8)) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_timeout),
    .i_clr   (1'b0),
    .o_count (o_timeout_count)
  );
endmodule
